// File: rtl/data_mem_ctrl_if.sv
// Core <-> data-memory request/response bundle.
//
// Handshake: the core raises MemRead and/or MemWrite with addr/wdata/funct3
// and keeps all request fields stable while stall is high. The responder
// captures the request on acceptance and completes it with a one-cycle ready
// pulse. mem_err is only meaningful while ready is high. rdata holds the
// result of the most recent successful load.
//
// Signals:
//   MemRead, MemWrite : request strobes (both high = store)
//   addr, wdata       : byte address and store data
//   funct3            : access size / signedness
//   rdata             : registered load result
//   ready             : completion pulse
//   stall             : pipeline freeze
//   mem_err           : completion was an illegal access with no effect
interface data_mem_ctrl_if #(parameter int DATA_W = 32);
  logic              MemRead;
  logic              MemWrite;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              stall;
  logic              mem_err;

  modport master (
    output MemRead, MemWrite, addr, wdata, funct3,
    input  rdata, ready, stall, mem_err
  );

  modport slave (
    input  MemRead, MemWrite, addr, wdata, funct3,
    output rdata, ready, stall, mem_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: byte/half/word loads and stores on an internal
// word-organised RAM with WAIT_CYCLES wait states, stall generation and
// sign/zero-extended load data.
//
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   bus     : data_mem_ctrl_if slave modport (request in, response out)
//   state_o : current FSM state for observation (0 IDLE, 1 WAIT, 2 RESP)
module data_mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_ctrl_if.slave       bus,
  output logic [1:0]           state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);
  localparam logic [DATA_W-3:0] DEPTH_L = (DATA_W-2)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       ram_q [DEPTH];

  // Access fields: straight from the bus while idle (needed when the access
  // commits on the acceptance edge with zero wait states), else captured.
  logic [DATA_W-1:0] acc_addr, acc_wdata;
  logic [2:0]        acc_f3;
  logic              acc_wr;
  logic [AW-1:0]     acc_idx;
  logic [1:0]        lane;
  logic              illegal;
  logic [31:0]       word, ld_val, st_data;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [3:0]        be;
  logic              ram_we;
  logic              req;
  logic              stall_w;

  assign req = bus.MemRead | bus.MemWrite;

  always_comb begin
    if (state_q == S_IDLE) begin
      acc_addr  = bus.addr;
      acc_wdata = bus.wdata;
      acc_f3    = bus.funct3;
      acc_wr    = bus.MemWrite;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_f3    = f3_q;
      acc_wr    = wr_q;
    end
  end

  assign acc_idx = acc_addr[AW+1:2];
  assign lane    = acc_addr[1:0];
  assign word    = ram_q[acc_idx];

  // Legality: alignment, funct3 encoding for the access direction, range.
  always_comb begin
    illegal = 1'b0;
    if (acc_f3[1:0] == 2'b01 && lane[0]) illegal = 1'b1;
    if (acc_f3[1:0] == 2'b10 && lane != 2'b00) illegal = 1'b1;
    if (acc_wr) begin
      if (acc_f3[2] || acc_f3[1:0] == 2'b11) illegal = 1'b1;
    end else begin
      if (acc_f3 == 3'b011 || acc_f3 == 3'b110 || acc_f3 == 3'b111) illegal = 1'b1;
    end
    if (acc_addr[DATA_W-1:2] >= DEPTH_L) illegal = 1'b1;
  end

  always_comb begin
    case (lane)
      2'd0:    ld_b = word[7:0];
      2'd1:    ld_b = word[15:8];
      2'd2:    ld_b = word[23:16];
      default: ld_b = word[31:24];
    endcase
    ld_h = lane[1] ? word[31:16] : word[15:0];
    case (acc_f3)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_val = {24'd0, ld_b};
      3'b101:  ld_val = {16'd0, ld_h};
      default: ld_val = word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables pick the slot.
  always_comb begin
    case (acc_f3[1:0])
      2'b00: begin
        be      = 4'b0001 << lane;
        st_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = acc_wdata[31:0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall_w = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          stall_w = 1'b1;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          f3_d    = bus.funct3;
          wr_d    = bus.MemWrite;
          cnt_d   = WAIT_L;
          state_d = (WAIT_L == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        stall_w = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Commit on the edge entering RESP.
    if (state_d == S_RESP && state_q != S_RESP) begin
      err_d = illegal;
      if (!illegal) begin
        if (acc_wr) ram_we  = 1'b1;
        else        rdata_d = ld_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is not reset; the reset term only blocks a write during reset.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram_q[acc_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.ready   = (state_q == S_RESP);
  assign bus.mem_err = (state_q == S_RESP) & err_q;
  assign bus.stall   = stall_w & ~rst;
  assign state_o     = state_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst2, rst0;

  data_mem_ctrl_if #(.DATA_W(32)) bus2 ();
  data_mem_ctrl_if #(.DATA_W(32)) bus0 ();
  logic [1:0] st2, st0;

  data_mem_ctrl #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2), .state_o(st2));
  data_mem_ctrl #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0), .state_o(st0));

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp2_q[$];  // {mem_err, rdata}
  logic [32:0] exp0_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (bus2.ready === 1'b1) begin
      if (exp2_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut2 unexpected ready: got ready=1 expected no response");
      end else begin
        logic [32:0] e;
        e = exp2_q.pop_front();
        chk("dut2 rdata", bus2.rdata, e[31:0]);
        chk("dut2 mem_err", 32'(bus2.mem_err), 32'(e[32]));
      end
    end
  end

  always @(negedge clk) begin
    if (bus0.ready === 1'b1) begin
      if (exp0_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut0 unexpected ready: got ready=1 expected no response");
      end else begin
        logic [32:0] e;
        e = exp0_q.pop_front();
        chk("dut0 rdata", bus0.rdata, e[31:0]);
        chk("dut0 mem_err", 32'(bus0.mem_err), 32'(e[32]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit sel0, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    if (sel0) begin
      bus0.MemRead = rd; bus0.MemWrite = wr; bus0.addr = a; bus0.wdata = wd; bus0.funct3 = f3;
    end else begin
      bus2.MemRead = rd; bus2.MemWrite = wr; bus2.addr = a; bus2.wdata = wd; bus2.funct3 = f3;
    end
  endtask

  task automatic access(input bit sel0, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] exp_rd, input bit exp_err);
    int lat;
    bit done;
    int exp_lat;
    exp_lat = sel0 ? 1 : 3;
    lat = 0;
    done = 1'b0;
    @(negedge clk);
    drive(sel0, rd, wr, a, wd, f3);
    if (sel0) exp0_q.push_back({exp_err, exp_rd});
    else      exp2_q.push_back({exp_err, exp_rd});
    #1;
    chk("state idle at request", 32'(sel0 ? st0 : st2), 32'd0);
    chk("stall at request", 32'(sel0 ? bus0.stall : bus2.stall), 32'd1);
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clk);
      if ((sel0 ? bus0.ready : bus2.ready) === 1'b1) begin
        done = 1'b1;
        lat = n;
      end else begin
        chk("stall during wait", 32'(sel0 ? bus0.stall : bus2.stall), 32'd1);
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL ready timeout: got no ready in 40 cycles expected latency %0d", exp_lat);
    end else begin
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("stall in resp", 32'(sel0 ? bus0.stall : bus2.stall), 32'd0);
    end
    drive(sel0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    rst2 = 1'b1;
    rst0 = 1'b1;
    repeat (2) @(negedge clk);
    bus2.MemRead = 1'b1;  // request during reset must not raise stall
    #1;
    chk("reset rdata", bus2.rdata, 32'd0);
    chk("reset ready", 32'(bus2.ready), 32'd0);
    chk("reset mem_err", 32'(bus2.mem_err), 32'd0);
    chk("reset stall", 32'(bus2.stall), 32'd0);
    chk("reset state", 32'(st2), 32'd0);
    bus2.MemRead = 1'b0;
    @(negedge clk);
    rst2 = 1'b0;
    rst0 = 1'b0;

    // Seed locations checked later.
    access(1'b0, 1'b0, 1'b1, 32'h0,  32'h0BADF00D, 3'b010, 32'h0, 1'b0);
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'h11111111, 3'b010, 32'h0, 1'b0);
    // Word round trip.
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h12345678, 3'b010, 32'h0, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        3'b010, 32'h12345678, 1'b0);
    // Byte / halfword stores and extending loads.
    access(1'b0, 1'b0, 1'b1, 32'h13, 32'h00000080, 3'b000, 32'h12345678, 1'b0);
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'h0000FF01, 3'b001, 32'h12345678, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'h8034FF01, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 3'b100, 32'h00000080, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b001, 32'hFFFFFF01, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b101, 32'h0000FF01, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF8034, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'h11, 32'h0, 3'b100, 32'h000000FF, 1'b0);
    // Errors: misaligned, bad funct3, out of range; RAM and rdata untouched.
    access(1'b0, 1'b1, 1'b0, 32'h12, 32'h0, 3'b010, 32'h000000FF, 1'b1);
    access(1'b0, 1'b1, 1'b0, 32'h11, 32'h0, 3'b001, 32'h000000FF, 1'b1);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b011, 32'h000000FF, 1'b1);
    access(1'b0, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 3'b100, 32'h000000FF, 1'b1);
    access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'h8034FF01, 1'b0);
    access(1'b0, 1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 3'b010, 32'h8034FF01, 1'b1);
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010, 32'h0BADF00D, 1'b0);
    // Both strobes high: store.
    access(1'b0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 3'b010, 32'h0BADF00D, 1'b0);
    access(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 3'b010, 32'hA5A5A5A5, 1'b0);

    // Reset during WAIT of a store aborts it.
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 32'h11111111, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 3'b010);
    @(posedge clk);
    #2;
    chk("abort in wait", 32'(st2), 32'd1);
    rst2 = 1'b1;
    #1;
    chk("abort rdata", bus2.rdata, 32'd0);
    chk("abort ready", 32'(bus2.ready), 32'd0);
    chk("abort stall", 32'(bus2.stall), 32'd0);
    chk("abort mem_err", 32'(bus2.mem_err), 32'd0);
    chk("abort state", 32'(st2), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 32'h11111111, 1'b0);

    // Zero wait states, back-to-back loads.
    access(1'b1, 1'b0, 1'b1, 32'h10, 32'h01020304, 3'b010, 32'h0, 1'b0);
    access(1'b1, 1'b0, 1'b1, 32'h14, 32'h05060708, 3'b010, 32'h0, 1'b0);
    access(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'h01020304, 1'b0);
    access(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 3'b010, 32'h05060708, 1'b0);

    for (int i = 0; i < 20 && (exp2_q.size() != 0 || exp0_q.size() != 0); i++) @(negedge clk);
    chk("dut2 queue drained", 32'(exp2_q.size()), 32'd0);
    chk("dut0 queue drained", 32'(exp0_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory responder for the single-issue RISC-V core. It consumes the MemRead/MemWrite strobes issued by the main decoder together with the ALU address, store data and funct3. It performs byte, half or word accesses on an internal word-organised RAM with a programmable wait-state count. It stalls the core until the access completes and returns sign- or zero-extended load data.

Parameters:
DATA_W, 32, data and address width in bits.
DEPTH, 256, RAM size in 32-bit words; must be a power of two.
WAIT_CYCLES, 2, wait states inserted before an access completes; the legal range is 0 to 15.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous and active-high.
MemRead  input  1  load request from the decoder.
MemWrite  input  1  store request from the decoder.
addr  input  DATA_W  byte address from the ALU.
wdata  input  DATA_W  store data (rs2).
funct3  input  3  access size: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use only 000 sb, 001 sh, 010 sw.
rdata  output  DATA_W  registered load result.
ready  output  1  one-cycle pulse marking completion of an access.
stall  output  1  freezes the PC and pipeline while high.
mem_err  output  1  qualifies ready: the access was illegal and had no effect.

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - the FSM is in IDLE;
  - rdata = 0, ready = 0, mem_err = 0, stall = 0;
  - the wait counter = 0.
- RAM contents are not reset.
- Reset mid-access aborts the access. If reset asserts before the commit edge, no RAM write occurs.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - A request is MemRead or MemWrite sampled high. If both are high, the access is a store.
  - stall is combinational: stall = (MemRead or MemWrite) while in IDLE.
  - On a request, register addr, wdata, funct3 and the access type, then load the counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES > 0; otherwise go to RESP.
- WAIT:
  - stall = 1.
  - The counter decrements each cycle.
  - When counter == 1, the next state is RESP.
- RESP:
  - ready = 1 and stall = 0 for exactly one cycle.
  - The next state is always IDLE, so a back-to-back request is accepted in the following cycle.
- Latency: a request first seen in cycle T produces ready in cycle T+WAIT_CYCLES+1. The core holds its request inputs stable while stall is high; changes to the inputs during WAIT are ignored because the values were captured at acceptance.
- Commit edge: the store write and the rdata update both occur on the clock edge entering RESP.
- rdata holds its value until the next successful load completes. Stores and errors leave rdata unchanged.
- Word index is addr[log2(DEPTH)+1:2]. The byte lane is addr[1:0].
- Store:
  - sb writes byte lane addr[1:0] with wdata[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - sw writes the whole word.
  - All other lanes are preserved.
- Load:
  - Select the byte or halfword at the lane.
  - lb and lh sign-extend; lbu and lhu zero-extend; lw returns the full word.
- Errors: mem_err = 1 together with ready, with the same latency as a normal access; the RAM and rdata are not modified. An access is illegal if any of the following holds:
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - load funct3 of 011, 110 or 111;
  - store funct3 other than 000, 001 or 010;
  - addr[DATA_W-1:2] >= DEPTH.
- mem_err is 0 whenever ready is 0.

Test Plan:
- Reset mid-access: WAIT_CYCLES=2; assert rst asynchronously during WAIT of a store of 0xDEADBEEF to 0x20 -> outputs clear immediately; a later lw of 0x20 returns the prior contents, not 0xDEADBEEF.
- Word round trip: WAIT_CYCLES=2; sw 0x12345678 to 0x10 (MemWrite high at cycle T) -> stall high in T..T+2, ready in T+3; lw of 0x10 -> rdata = 0x12345678 in the ready cycle.
- Byte and halfword stores with extension:
  - Stimulus: after the previous word, sb 0x80 to 0x13, then sh 0xFF01 to 0x10.
  - lw 0x10 -> 0x8034FF01.
  - lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080.
  - lh 0x10 -> 0xFFFFFF01; lhu 0x10 -> 0x0000FF01.
- Zero-wait back-to-back: WAIT_CYCLES=0; two consecutive loads of 0x10 and 0x14 -> each ready pulse arrives one cycle after acceptance; IDLE is re-entered between them; rdata updates on each pulse.
- Errors:
  - lw 0x12 -> ready=1, mem_err=1, rdata unchanged.
  - sw to address DEPTH*4 -> mem_err=1; a following lw of 0x0 shows the RAM unchanged.
- Simultaneous strobes: MemRead=MemWrite=1 with sw data 0xA5A5A5A5 to 0x8 -> treated as a store; rdata unchanged; a later lw 0x8 returns 0xA5A5A5A5.
